// File: rtl/load_store_unit.sv
// Load/store unit: multi-cycle RV32I LB/LH/LW/LBU/LHU/SB/SH/SW stage.
// It drives a word-wide request/acknowledge data-memory bus and returns
// sign- or zero-extended load data for register write-back.
// Define LOAD_STORE_UNIT_STATS_EN to add saturating load/store/fault counters.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef LOAD_STORE_UNIT_STATS_EN
  ,
  output logic [15:0] stat_loads,
  output logic [15:0] stat_stores,
  output logic [15:0] stat_faults
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_MISALIGN = 2'b01;
  localparam logic [1:0] CODE_ILLEGAL = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT = 2'b11;

  localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic        op_store_q, op_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] load_data_q, load_data_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        start_legal;
  logic        start_misaligned;
  logic [1:0]  start_code;
  logic [3:0]  start_be;
  logic [31:0] start_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  // Decode the incoming request: legality, alignment and store byte lanes.
  always_comb begin
    start_legal      = 1'b0;
    start_misaligned = 1'b0;
    start_be         = 4'b1111;
    start_wdata      = store_data;
    if (op_store) begin
      start_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      start_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
    end
    start_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    if (!start_legal) begin
      start_code = CODE_ILLEGAL;
    end else if (start_misaligned) begin
      start_code = CODE_MISALIGN;
    end else begin
      start_code = CODE_NONE;
    end
    if (op_store) begin
      case (funct3[1:0])
        2'b00: begin
          start_be    = 4'b0001 << addr[1:0];
          start_wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          start_be    = 4'b0011 << {addr[1], 1'b0};
          start_wdata = {2{store_data[15:0]}};
        end
        default: begin
          start_be    = 4'b1111;
          start_wdata = store_data;
        end
      endcase
    end
  end

  // Select and extend the addressed byte/half from the returned word.
  always_comb begin
    rd_byte = mem_rdata[7:0];
    case (addr_lo_q)
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    rd_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  rd_ext = {24'd0, rd_byte};
      3'b101:  rd_ext = {16'd0, rd_half};
      default: rd_ext = mem_rdata;
    endcase
  end

  // Next-state logic. A faulted request still passes through REQ (with the
  // bus request suppressed) so fault and fast-ack accesses share the same
  // two-cycle start-to-done latency.
  always_comb begin
    state_d     = state_q;
    op_store_d  = op_store_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    err_code_d  = err_code_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_store_d = op_store;
          funct3_d   = funct3;
          addr_lo_d  = addr[1:0];
          err_code_d = start_code;
          cnt_d      = 32'd0;
          state_d    = S_REQ;
          if (start_code == CODE_NONE) begin
            mem_we_d    = op_store;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = start_be;
            mem_wdata_d = start_wdata;
          end
        end
      end
      S_REQ: begin
        if (err_code_q != CODE_NONE) begin
          state_d = S_RESP;
        end else if (mem_ack) begin
          state_d = S_RESP;
          if (!op_store_q) begin
            load_data_d = rd_ext;
          end
        end else if ((TIMEOUT_LIMIT != 32'd0) && ((cnt_q + 32'd1) == TIMEOUT_LIMIT)) begin
          state_d    = S_RESP;
          err_code_d = CODE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      err_code_q  <= CODE_NONE;
      cnt_q       <= 32'd0;
      load_data_q <= 32'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      op_store_q  <= op_store_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      err_code_q  <= err_code_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_RESP);
  assign mem_req   = (state_q == S_REQ) && (err_code_q == CODE_NONE);
  assign mem_we    = mem_we_q && mem_req;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign load_data = load_data_q;
  assign err       = (err_code_q != CODE_NONE);
  assign err_code  = err_code_q;

`ifdef LOAD_STORE_UNIT_STATS_EN
  logic [15:0] stat_loads_q, stat_loads_d;
  logic [15:0] stat_stores_q, stat_stores_d;
  logic [15:0] stat_faults_q, stat_faults_d;

  // Count each completed access once, faults taking precedence over type.
  always_comb begin
    stat_loads_d  = stat_loads_q;
    stat_stores_d = stat_stores_q;
    stat_faults_d = stat_faults_q;
    if (state_q == S_RESP) begin
      if (err_code_q != CODE_NONE) begin
        if (stat_faults_q != 16'hFFFF) stat_faults_d = stat_faults_q + 16'd1;
      end else if (op_store_q) begin
        if (stat_stores_q != 16'hFFFF) stat_stores_d = stat_stores_q + 16'd1;
      end else begin
        if (stat_loads_q != 16'hFFFF) stat_loads_d = stat_loads_q + 16'd1;
      end
    end
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loads_q  <= 16'd0;
      stat_stores_q <= 16'd0;
      stat_faults_q <= 16'd0;
    end else begin
      stat_loads_q  <= stat_loads_d;
      stat_stores_q <= stat_stores_d;
      stat_faults_q <= stat_faults_d;
    end
  end

  assign stat_loads  = stat_loads_q;
  assign stat_stores = stat_stores_q;
  assign stat_faults = stat_faults_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: table of directed accesses plus hand-written
// reset-during-request and timeout sequences. Built with TIMEOUT_CYCLES=4.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        err;
  logic [1:0]  err_code;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef LOAD_STORE_UNIT_STATS_EN
  logic [15:0] stat_loads;
  logic [15:0] stat_stores;
  logic [15:0] stat_faults;
`endif

  int checks = 0;
  int failures = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_store   (op_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .err        (err),
    .err_code   (err_code),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
`ifdef LOAD_STORE_UNIT_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_faults (stat_faults)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op_store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          ack_delay;
    int          exp_req_cycles;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_we;
    logic        chk_w;
    logic [31:0] exp_ld;
    logic [1:0]  exp_code;
    int          exp_lat;
    int          spur_at;
  } vec_t;

  vec_t vecs[15];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one access: drives start, acts as memory, checks the bus and result.
  task automatic applyStimulus(input string tag, input vec_t v);
    int n;
    int req_cycles;
    int done_cycle;
    int extra;
    logic stable;
    logic busy_at_done;
    logic err_at_done;
    logic [1:0] code_at_done;
    logic [31:0] ld_at_done;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_be;
    logic        a_we;
    a_addr = 0; a_wdata = 0; a_be = 0; a_we = 0;
    busy_at_done = 0; err_at_done = 0; code_at_done = 0; ld_at_done = 0;
    @(negedge clk);
    start = 1'b1; op_store = v.op_store; funct3 = v.f3; addr = v.addr; store_data = v.sd;
    @(negedge clk);
    start = 1'b0;
    n = 1; req_cycles = 0; done_cycle = -1; stable = 1'b1;
    while (n < 20 && done_cycle < 0) begin
      mem_ack = 1'b0;
      start = (n == v.spur_at);
      if (mem_req) begin
        if (req_cycles == 0) begin
          a_addr = mem_addr; a_be = mem_be; a_wdata = mem_wdata; a_we = mem_we;
        end else if (mem_addr !== a_addr || mem_be !== a_be || mem_wdata !== a_wdata || mem_we !== a_we) begin
          stable = 1'b0;
        end
        if (req_cycles == v.ack_delay) begin
          mem_ack = 1'b1;
          mem_rdata = v.rdata;
        end
        req_cycles++;
      end
      if (done) begin
        done_cycle = n;
        busy_at_done = busy; err_at_done = err; code_at_done = err_code; ld_at_done = load_data;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    mem_ack = 1'b0;
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || mem_req) extra++;
      @(negedge clk);
    end
    checkOutput({tag, " latency"}, 32'(done_cycle), 32'(v.exp_lat));
    checkOutput({tag, " req_cycles"}, 32'(req_cycles), 32'(v.exp_req_cycles));
    checkOutput({tag, " busy_at_done"}, {31'd0, busy_at_done}, 32'd1);
    checkOutput({tag, " err"}, {31'd0, err_at_done}, {31'd0, v.exp_code != 2'b00});
    checkOutput({tag, " err_code"}, {30'd0, code_at_done}, {30'd0, v.exp_code});
    checkOutput({tag, " load_data"}, ld_at_done, v.exp_ld);
    checkOutput({tag, " extra_activity"}, 32'(extra), 32'd0);
    if (v.exp_req_cycles > 0 && req_cycles > 0) begin
      checkOutput({tag, " mem_addr"}, a_addr, v.exp_addr);
      checkOutput({tag, " mem_be"}, {28'd0, a_be}, {28'd0, v.exp_be});
      checkOutput({tag, " mem_we"}, {31'd0, a_we}, {31'd0, v.exp_we});
      checkOutput({tag, " bus_stable"}, {31'd0, stable}, 32'd1);
      if (v.chk_w) checkOutput({tag, " mem_wdata"}, a_wdata, v.exp_wdata);
    end
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int late_done;
    vec_t v;
    // op, f3, addr, sd, rdata, ackd, reqc, eaddr, ebe, ewdata, ewe, chkw, eld, ecode, lat, spur
    vecs[0]  = '{1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0, 1, 32'h104, 4'b1111, 32'hDEADBEEF, 1'b1, 1'b1, 32'h0, 2'b00, 2, 2};
    vecs[1]  = '{1'b0, 3'b000, 32'h203, 32'h0, 32'h80112233, 0, 1, 32'h200, 4'b1111, 32'h0, 1'b0, 1'b0, 32'hFFFFFF80, 2'b00, 2, -1};
    vecs[2]  = '{1'b0, 3'b100, 32'h203, 32'h0, 32'h80112233, 0, 1, 32'h200, 4'b1111, 32'h0, 1'b0, 1'b0, 32'h00000080, 2'b00, 2, -1};
    vecs[3]  = '{1'b1, 3'b001, 32'h012, 32'h0000ABCD, 32'h0, 0, 1, 32'h010, 4'b1100, 32'hABCDABCD, 1'b1, 1'b1, 32'h00000080, 2'b00, 2, -1};
    vecs[4]  = '{1'b0, 3'b001, 32'h012, 32'h0, 32'h7FFF0000, 0, 1, 32'h010, 4'b1111, 32'h0, 1'b0, 1'b0, 32'h00007FFF, 2'b00, 2, -1};
    vecs[5]  = '{1'b0, 3'b010, 32'h006, 32'h0, 32'h0, -1, 0, 32'h0, 4'b0, 32'h0, 1'b0, 1'b0, 32'h00007FFF, 2'b01, 2, -1};
    vecs[6]  = '{1'b0, 3'b011, 32'h000, 32'h0, 32'h0, -1, 0, 32'h0, 4'b0, 32'h0, 1'b0, 1'b0, 32'h00007FFF, 2'b10, 2, -1};
    vecs[7]  = '{1'b1, 3'b000, 32'h021, 32'h000000A5, 32'h0, 0, 1, 32'h020, 4'b0010, 32'hA5A5A5A5, 1'b1, 1'b1, 32'h00007FFF, 2'b00, 2, -1};
    vecs[8]  = '{1'b0, 3'b101, 32'h102, 32'h0, 32'h80011234, 2, 3, 32'h100, 4'b1111, 32'h0, 1'b0, 1'b0, 32'h00008001, 2'b00, 4, -1};
    vecs[9]  = '{1'b0, 3'b001, 32'h100, 32'h0, 32'h00008001, 0, 1, 32'h100, 4'b1111, 32'h0, 1'b0, 1'b0, 32'hFFFF8001, 2'b00, 2, -1};
    vecs[10] = '{1'b0, 3'b010, 32'h300, 32'h0, 32'h12345678, 3, 4, 32'h300, 4'b1111, 32'h0, 1'b0, 1'b0, 32'h12345678, 2'b00, 5, -1};
    vecs[11] = '{1'b1, 3'b011, 32'h001, 32'h0, 32'h0, -1, 0, 32'h0, 4'b0, 32'h0, 1'b0, 1'b0, 32'h12345678, 2'b10, 2, -1};
    vecs[12] = '{1'b1, 3'b001, 32'h011, 32'h0, 32'h0, -1, 0, 32'h0, 4'b0, 32'h0, 1'b0, 1'b0, 32'h12345678, 2'b01, 2, -1};
    vecs[13] = '{1'b0, 3'b000, 32'h201, 32'h0, 32'h00007F00, 0, 1, 32'h200, 4'b1111, 32'h0, 1'b0, 1'b0, 32'h0000007F, 2'b00, 2, -1};
    vecs[14] = '{1'b0, 3'b010, 32'h400, 32'h0, 32'h0, -1, 4, 32'h400, 4'b1111, 32'h0, 1'b0, 1'b0, 32'h0000007F, 2'b11, 5, 2};

    rst = 1'b1; start = 1'b0; op_store = 1'b0; funct3 = 3'b000; addr = 32'h0;
    store_data = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy_done_err_req_we", {27'd0, busy, done, err, mem_req, mem_we}, 32'd0);
    checkOutput("reset err_code_be", {26'd0, err_code, mem_be}, 32'd0);
    checkOutput("reset load_data", load_data, 32'd0);
    checkOutput("reset mem_addr", mem_addr, 32'd0);
    checkOutput("reset mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset while a request is outstanding, then a late acknowledge.
    @(negedge clk);
    start = 1'b1; op_store = 1'b0; funct3 = 3'b010; addr = 32'h500;
    @(negedge clk);
    start = 1'b0;
    checkOutput("rst_seq req_before", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_seq req_after", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_seq busy_after", {31'd0, busy}, 32'd0);
    checkOutput("rst_seq load_data", load_data, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    late_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) mem_ack = 1'b0;
      @(negedge clk);
      if (done || mem_req || busy) late_done++;
    end
    checkOutput("rst_seq late_ack_activity", 32'(late_done), 32'd0);

    v = '{1'b0, 3'b010, 32'h504, 32'h0, 32'hCAFEF00D, 0, 1, 32'h504, 4'b1111, 32'h0, 1'b0, 1'b0, 32'hCAFEF00D, 2'b00, 2, -1};
    applyStimulus("post_rst_lw", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
